alu_rr_scheduler: RTL and testbench

//  Shares one 2-stage pipelined ALU (alu_pipelined) between NUM_REQ requesters.

---
 rtl/alu_defines.sv | 24 ++
 rtl/alu_pipelined.sv | 62 ++++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/alu_rr_scheduler.sv | 107 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/alu_defines.sv
// Shared ALU opcodes plus the scheduler's in-flight tag type.
package alu_defines;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_t;

  localparam int unsigned ALU_LATENCY = 2;
  // Wide enough for the largest supported requester count (16).
  localparam int unsigned TAG_ID_W    = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } sched_tag_t;

endpackage

// File: rtl/alu_pipelined.sv
// Two-stage pipelined ALU: operand register stage, then result register stage.
module alu_pipelined
  import alu_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_t               op,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int unsigned SH_W = $clog2(DATA_WIDTH);

  logic                  v1_q, v2_q;
  logic [DATA_WIDTH-1:0] a1_q, b1_q, y_q, res;
  alu_op_t               op1_q;
  logic [SH_W-1:0]       sh;

  always_comb begin
    sh  = b1_q[SH_W-1:0];
    res = '0;
    case (op1_q)
      ALU_ADD: res = a1_q + b1_q;
      ALU_SUB: res = a1_q - b1_q;
      ALU_AND: res = a1_q & b1_q;
      ALU_OR:  res = a1_q | b1_q;
      ALU_XOR: res = a1_q ^ b1_q;
      ALU_SLL: res = a1_q << sh;
      ALU_SRL: res = a1_q >> sh;
      ALU_SRA: res = DATA_WIDTH'($signed(a1_q) >>> sh);
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      op1_q <= ALU_ADD;
      y_q   <= '0;
    end else begin
      v1_q  <= valid_in & ~flush;
      v2_q  <= v1_q & ~flush;
      a1_q  <= a;
      b1_q  <= b;
      op1_q <= op;
      y_q   <= res;
    end
  end

  assign valid_out = v2_q;
  assign y         = y_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first eligible requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ID_W'((32'(ptr) + k) % N);
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end sharing one pipelined ALU between NUM_REQ requesters,
// with a tag pipe that routes each result back to the requester that issued it.
module alu_rr_scheduler
  import alu_defines::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b,
  input  alu_op_t [NUM_REQ-1:0]                req_op,
  input  logic [NUM_REQ-1:0]                   req_mask,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_y,
  output logic                                 alu_valid_in,
  output logic [DATA_WIDTH-1:0]                alu_a,
  output logic [DATA_WIDTH-1:0]                alu_b,
  output alu_op_t                              alu_op,
  output logic                                 alu_flush,
  input  logic                                 alu_valid_out,
  input  logic [DATA_WIDTH-1:0]                alu_y,
  output logic [31:0]                          issue_count,
  output logic                                 err_sticky
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              eligible, grant;
  logic [ID_W-1:0]                 grant_id, ptr_q, ptr_d;
  logic                            transfer, tag_mismatch, resp_fire;
  sched_tag_t [ALU_LATENCY-1:0]    tag_q, tag_d;
  logic [31:0]                     issue_count_q, issue_count_d;
  logic                            err_q, err_d;

  assign eligible = req_valid & req_mask;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Nothing is accepted while in reset or while flushing.
  always_comb begin
    req_ready    = (rst || flush) ? '0 : grant;
    transfer     = |req_ready;
    alu_valid_in = transfer;
    alu_a        = req_a[grant_id];
    alu_b        = req_b[grant_id];
    alu_op       = req_op[grant_id];
    alu_flush    = flush;
  end

  // Results are routed by the oldest tag; a flush also hides the result leaving the ALU now.
  always_comb begin
    tag_mismatch = alu_valid_out != tag_q[ALU_LATENCY-1].valid;
    resp_fire    = alu_valid_out && tag_q[ALU_LATENCY-1].valid && !flush && !rst;
    resp_valid   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = resp_fire && (tag_q[ALU_LATENCY-1].id == TAG_ID_W'(i));
    end
    resp_y = alu_y;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = ID_W'((32'(grant_id) + 32'd1) % NUM_REQ);
    end
    tag_d[0].valid = transfer;
    tag_d[0].id    = TAG_ID_W'(grant_id);
    for (int unsigned s = 1; s < ALU_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    if (flush) begin
      for (int unsigned s = 0; s < ALU_LATENCY; s++) begin
        tag_d[s].valid = 1'b0;
      end
    end
    issue_count_d = issue_count_q + 32'(transfer);
    err_d         = err_q | tag_mismatch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      tag_q         <= '0;
      issue_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      tag_q         <= tag_d;
      issue_count_q <= issue_count_d;
      err_q         <= err_d;
    end
  end

  assign issue_count = issue_count_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench: scheduler driving a real alu_pipelined, checked against hand-computed vectors.
module tb_alu_rr_scheduler;
  import alu_defines::*;

  logic              clk;
  logic              rst, flush;
  logic [3:0]        req_valid, req_ready, req_mask, resp_valid;
  logic [3:0][31:0]  req_a, req_b;
  alu_op_t [3:0]     req_op;
  logic [31:0]       resp_y, alu_a, alu_b, alu_y, issue_count;
  alu_op_t           alu_op;
  logic              alu_valid_in, alu_flush, alu_valid_out_raw, alu_valid_out;
  logic              err_sticky, force_vout;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign alu_valid_out = alu_valid_out_raw | force_vout;

  alu_rr_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_y(resp_y),
    .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_flush(alu_flush), .alu_valid_out(alu_valid_out), .alu_y(alu_y),
    .issue_count(issue_count), .err_sticky(err_sticky)
  );

  alu_pipelined #(.DATA_WIDTH(32)) u_alu (
    .clk(clk), .rst(rst), .flush(alu_flush), .valid_in(alu_valid_in),
    .a(alu_a), .b(alu_b), .op(alu_op), .valid_out(alu_valid_out_raw), .y(alu_y)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [3:0]  valid;
    logic [3:0]  mask;
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] bb;     // requester i gets b = bb + i
    logic [3:0]  ready;
    logic [3:0]  resp;
    logic [31:0] y;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v,
                              input logic [3:0] m, input alu_op_t op, input logic [31:0] a,
                              input logic [31:0] bb, input logic [3:0] rdy,
                              input logic [3:0] rsp, input logic [31:0] y);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.mask = m; t.op = op;
    t.a = a; t.bb = bb; t.ready = rdy; t.resp = rsp; t.y = y;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [3:0] v, input logic [3:0] m,
                       input alu_op_t op, input logic [31:0] a, input logic [31:0] bb);
    rst = r; flush = f; req_valid = v; req_mask = m;
    for (int i = 0; i < 4; i++) begin
      req_a[i]  = a;
      req_b[i]  = bb + 32'(i);
      req_op[i] = op;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    force_vout = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 4'hF, ALU_ADD, 32'd1, 32'd1);

    // Reset held two cycles with every requester valid.
    for (int c = 0; c < 2; c++) begin
      #2;
      check($sformatf("reset%0d ready", c), 32'(req_ready), 32'd0);
      check($sformatf("reset%0d alu_valid_in", c), 32'(alu_valid_in), 32'd0);
      check($sformatf("reset%0d resp_valid", c), 32'(resp_valid), 32'd0);
      if (c == 1) check("reset issue_count", issue_count, 32'd0);
      next_cycle();
    end

    // Single requester ADD 5+7 on req1.
    tbl.push_back(mk(0, 0, 4'b0010, 4'hF, ALU_ADD, 32'd5,   32'd6,  4'b0010, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_ADD, 32'd5,   32'd6,  4'b0000, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_ADD, 32'd5,   32'd6,  4'b0000, 4'b0010, 32'd12));
    tbl.push_back(mk(1, 0, 4'b0000, 4'hF, ALU_ADD, 32'd0,   32'd0,  4'b0000, 4'b0000, 32'd0));
    // Fairness: all valid, SUB 100-i.
    tbl.push_back(mk(0, 0, 4'b1111, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b0001, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b1111, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b0010, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b1111, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b0100, 4'b0001, 32'd100));
    tbl.push_back(mk(0, 0, 4'b1111, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b1000, 4'b0010, 32'd99));
    tbl.push_back(mk(0, 0, 4'b1111, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b0001, 4'b0100, 32'd98));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b0000, 4'b1000, 32'd97));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b0000, 4'b0001, 32'd100));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_SUB, 32'd100, 32'd0,  4'b0000, 4'b0000, 32'd0));
    // Mask and wrap: ptr=1, mask=1001, req1 valid but masked.
    tbl.push_back(mk(0, 0, 4'b1011, 4'b1001, ALU_ADD, 32'd10, 32'd0, 4'b1000, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0011, 4'b1001, ALU_ADD, 32'd10, 32'd0, 4'b0001, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b1001, ALU_ADD, 32'd10, 32'd0, 4'b0000, 4'b1000, 32'd13));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b1001, ALU_ADD, 32'd10, 32'd0, 4'b0000, 4'b0001, 32'd10));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b1001, ALU_ADD, 32'd10, 32'd0, 4'b0000, 4'b0000, 32'd0));
    // Flush: req2 XOR, req3 SLL, then flush with req0 pending.
    tbl.push_back(mk(0, 0, 4'b0100, 4'hF, ALU_XOR, 32'hF0,  32'd13, 4'b0100, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b1000, 4'hF, ALU_SLL, 32'hF0,  32'd1,  4'b1000, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 1, 4'b0001, 4'hF, ALU_ADD, 32'd1,   32'd1,  4'b0000, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0001, 4'hF, ALU_ADD, 32'd1,   32'd1,  4'b0001, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_ADD, 32'd1,   32'd1,  4'b0000, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_ADD, 32'd1,   32'd1,  4'b0000, 4'b0001, 32'd2));
    // Back-to-back issue from a single requester.
    tbl.push_back(mk(0, 0, 4'b0100, 4'hF, ALU_ADD, 32'd20,  32'd0,  4'b0100, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0100, 4'hF, ALU_ADD, 32'd21,  32'd0,  4'b0100, 4'b0000, 32'd0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_ADD, 32'd0,   32'd0,  4'b0000, 4'b0100, 32'd22));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_ADD, 32'd0,   32'd0,  4'b0000, 4'b0100, 32'd23));
    tbl.push_back(mk(0, 0, 4'b0000, 4'hF, ALU_ADD, 32'd0,   32'd0,  4'b0000, 4'b0000, 32'd0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].mask, tbl[i].op, tbl[i].a, tbl[i].bb);
      #2;
      check($sformatf("row%0d ready", i), 32'(req_ready), 32'(tbl[i].ready));
      check($sformatf("row%0d alu_valid_in", i), 32'(alu_valid_in), 32'(|tbl[i].ready));
      check($sformatf("row%0d resp_valid", i), 32'(resp_valid), 32'(tbl[i].resp));
      if (tbl[i].resp != 4'b0000) check($sformatf("row%0d resp_y", i), resp_y, tbl[i].y);
      next_cycle();
    end
    check("issue_count after table", issue_count, 32'd12);
    check("err_sticky clean", 32'(err_sticky), 32'd0);

    // Counter wrap: preload all-ones through the next-state value, then one transfer.
    drive(1'b0, 1'b0, 4'b0000, 4'hF, ALU_ADD, 32'd0, 32'd0);
    force dut.issue_count_d = 32'hFFFF_FFFF;
    next_cycle();
    release dut.issue_count_d;
    #2;
    check("issue_count preload", issue_count, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b0, 1'b0, 4'b0001, 4'hF, ALU_ADD, 32'd0, 32'd0);
    #2;
    check("wrap transfer ready", 32'(req_ready), 32'b0001);
    next_cycle();
    drive(1'b0, 1'b0, 4'b0000, 4'hF, ALU_ADD, 32'd0, 32'd0);
    #2;
    check("issue_count wrap", issue_count, 32'd0);
    for (int c = 0; c < 3; c++) next_cycle();

    // Spurious ALU valid with an empty tag pipe.
    force_vout = 1'b1;
    #2;
    check("spurious resp_valid", 32'(resp_valid), 32'd0);
    next_cycle();
    force_vout = 1'b0;
    #2;
    check("err_sticky set", 32'(err_sticky), 32'd1);
    for (int c = 0; c < 2; c++) next_cycle();
    check("err_sticky held", 32'(err_sticky), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
